fetch_line_buffer: RTL and testbench

- Frontend stage directly downstream of the I-cache.
- Accepts whole cache lines (icache_out_t: pc + line) over a valid/ready handshake and buffers up to two lines.
- Delivers one 32-bit instruction per cycle, with its PC, to the decode/instruction-selector stage over a second valid/ready handshake.
- A flush, on redirect or mispredict, discards all buffered content.

---
 rtl/fetch_line_buffer.sv | 141 ++++++++++++++
 tb/tb_fetch_line_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_line_buffer
//  Purpose  : Two-line buffer between the I-cache and decode that issues one
//             instruction (with its PC) per cycle from the head line.
//  Revision : 1.0 - initial release
// ============================================================================

package fetch_pkg;
    localparam int XLEN            = 32;
    localparam int ILEN            = 32;
    localparam int ICACHE_INSTR    = 32;
    localparam int ICACHE_LINE_LEN = ICACHE_INSTR * ILEN;
    localparam int OFFSET          = $clog2(ILEN / 8);
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]            pc;
        logic [ICACHE_LINE_LEN-1:0] line;
    } icache_out_t;
endpackage

module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter int LINE_INSTR = ICACHE_INSTR,
    parameter int IDX_W      = $clog2(LINE_INSTR)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              line_valid_i,
    output logic              line_ready_o,
    input  icache_out_t       line_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [ILEN-1:0]   instr_o,
    output logic [XLEN-1:0]   instr_pc_o,
    output logic [1:0]        occupancy_o
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(LINE_INSTR - 1);

    logic                       head_valid_q, head_valid_d;
    logic [ICACHE_LINE_LEN-1:0] head_line_q,  head_line_d;
    logic [XLEN-1:0]            head_pc_q,    head_pc_d;
    logic                       tail_valid_q, tail_valid_d;
    logic [ICACHE_LINE_LEN-1:0] tail_line_q,  tail_line_d;
    logic [XLEN-1:0]            tail_pc_q,    tail_pc_d;
    logic [IDX_W-1:0]           idx_q,        idx_d;

    logic w_fire;
    logic w_wrap;
    logic w_push;
    logic w_unused_head_pc;

    assign instr_valid_o = head_valid_q & ~flush_i;
    assign line_ready_o  = ~tail_valid_q & ~flush_i;
    assign occupancy_o   = {1'b0, head_valid_q} + {1'b0, tail_valid_q};

    assign instr_o    = head_valid_q ? head_line_q[idx_q*ILEN +: ILEN] : NOP;
    assign instr_pc_o = head_valid_q
                      ? {head_pc_q[XLEN-1:OFFSET+IDX_W], idx_q, {OFFSET{1'b0}}}
                      : '0;

    // Only the line tag of the head PC is needed; idx tracks the rest.
    assign w_unused_head_pc = ^head_pc_q[OFFSET+IDX_W-1:0];

    assign w_fire = instr_valid_o & instr_ready_i;
    assign w_wrap = w_fire & (idx_q == c_LAST_IDX);
    assign w_push = line_valid_i & line_ready_o;

    always_comb begin
        head_valid_d = head_valid_q;
        head_line_d  = head_line_q;
        head_pc_d    = head_pc_q;
        tail_valid_d = tail_valid_q;
        tail_line_d  = tail_line_q;
        tail_pc_d    = tail_pc_q;
        idx_d        = idx_q;

        if (flush_i) begin
            head_valid_d = 1'b0;
            tail_valid_d = 1'b0;
            idx_d        = '0;
        end else begin
            if (w_fire && !w_wrap) begin
                idx_d = idx_q + 1'b1;
            end

            if (w_wrap) begin
                if (tail_valid_q) begin
                    head_valid_d = 1'b1;
                    head_line_d  = tail_line_q;
                    head_pc_d    = tail_pc_q;
                    tail_valid_d = 1'b0;
                    idx_d        = tail_pc_q[OFFSET +: IDX_W];
                end else begin
                    head_valid_d = 1'b0;
                end
            end

            // A push only happens with the tail empty, so it never collides
            // with the tail-to-head promotion above.
            if (w_push) begin
                if (!head_valid_q || (w_wrap && !tail_valid_q)) begin
                    head_valid_d = 1'b1;
                    head_line_d  = line_i.line;
                    head_pc_d    = line_i.pc;
                    idx_d        = line_i.pc[OFFSET +: IDX_W];
                end else begin
                    tail_valid_d = 1'b1;
                    tail_line_d  = line_i.line;
                    tail_pc_d    = line_i.pc;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_valid_q <= 1'b0;
            head_line_q  <= '0;
            head_pc_q    <= '0;
            tail_valid_q <= 1'b0;
            tail_line_q  <= '0;
            tail_pc_q    <= '0;
            idx_q        <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_line_q  <= head_line_d;
            head_pc_q    <= head_pc_d;
            tail_valid_q <= tail_valid_d;
            tail_line_q  <= tail_line_d;
            tail_pc_q    <= tail_pc_d;
            idx_q        <= idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_line_buffer
//  Purpose  : Self-checking bench for fetch_line_buffer against a queue-of-lines
//             model, with directed scenarios followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_line_buffer;
    import fetch_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              line_valid;
    logic              line_ready;
    icache_out_t       line_in;
    logic              instr_valid;
    logic              instr_ready;
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   instr_pc;
    logic [1:0]        occ;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [XLEN-1:0]            base;
        logic [ICACHE_LINE_LEN-1:0] data;
        int                         k;
    } mline_t;
    mline_t mq[$];

    fetch_line_buffer dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .line_valid_i  (line_valid),
        .line_ready_o  (line_ready),
        .line_i        (line_in),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .occupancy_o   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ICACHE_LINE_LEN-1:0] mk_data(input bit ramp);
        logic [ICACHE_LINE_LEN-1:0] d;
        for (int k = 0; k < ICACHE_INSTR; k++)
            d[k*ILEN +: ILEN] = ramp ? 32'(k + 1) : $urandom;
        return d;
    endfunction

    task automatic present(input logic [XLEN-1:0] pc, input bit ramp);
        line_valid   = 1'b1;
        line_in.pc   = pc;
        line_in.line = mk_data(ramp);
    endtask

    // Expected outputs follow from the model's queue of buffered lines.
    task automatic compare_all();
        logic [ILEN-1:0] w;
        check("instr_valid", {31'b0, instr_valid}, {31'b0, (mq.size() > 0) && !flush});
        check("line_ready",  {31'b0, line_ready},  {31'b0, (mq.size() < 2) && !flush});
        check("occupancy",   {30'b0, occ},         32'(mq.size()));
        if (mq.size() == 0) begin
            check("instr_idle", instr, NOP);
            check("pc_idle", instr_pc, 32'h0);
        end else if (!flush) begin
            w = mq[0].data[mq[0].k*ILEN +: ILEN];
            check("instr", instr, w);
            check("instr_pc", instr_pc, (mq[0].base & ~32'h7F) + 32'(4 * mq[0].k));
        end
    endtask

    task automatic model_step();
        bit     fire;
        bit     push;
        mline_t n;
        if (flush) begin
            mq.delete();
            return;
        end
        fire = (mq.size() > 0) && instr_ready;
        push = line_valid && (mq.size() < 2);
        if (fire) begin
            mq[0].k++;
            if (mq[0].k == ICACHE_INSTR) void'(mq.pop_front());
        end
        if (push) begin
            n.base = line_in.pc;
            n.data = line_in.line;
            n.k    = int'(line_in.pc[6:2]);
            mq.push_back(n);
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        #1;
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        line_valid   = 1'b0;
        instr_ready  = 1'b0;
        line_in      = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_ready", {31'b0, line_ready}, 32'h1);
        check("rst_occ",   {30'b0, occ}, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc",    instr_pc, 32'h0);
        rst_n = 1'b1;

        // Full line from an aligned PC.
        instr_ready = 1'b1;
        present(32'h1000, 1'b1);
        step();
        line_valid = 1'b0;
        check("t1_first_instr", instr, 32'h1);
        check("t1_first_pc", instr_pc, 32'h1000);
        repeat (31) step();
        check("t1_last_instr", instr, 32'h20);
        check("t1_last_pc", instr_pc, 32'h107C);
        step();
        check("t1_done_valid", {31'b0, instr_valid}, 32'h0);
        check("t1_done_occ", {30'b0, occ}, 32'h0);

        // Mid-line start followed by the next line without a bubble.
        present(32'h2070, 1'b0);
        step();
        check("t2_pc0", instr_pc, 32'h2070);
        present(32'h2080, 1'b0);
        step();
        line_valid = 1'b0;
        check("t2_pc1", instr_pc, 32'h2074);
        check("t2_occ2", {30'b0, occ}, 32'h2);
        check("t2_ready0", {31'b0, line_ready}, 32'h0);
        step();
        check("t2_pc2", instr_pc, 32'h2078);
        step();
        check("t2_pc3", instr_pc, 32'h207C);
        step();
        check("t2_pc4", instr_pc, 32'h2080);
        check("t2_valid4", {31'b0, instr_valid}, 32'h1);

        // Stall with both slots full.
        instr_ready = 1'b0;
        present(32'h2100, 1'b0);
        step();
        line_valid = 1'b0;
        repeat (10) begin
            step();
            check("t3_hold_pc", instr_pc, 32'h2080);
            check("t3_hold_occ", {30'b0, occ}, 32'h2);
            check("t3_hold_ready", {31'b0, line_ready}, 32'h0);
        end
        instr_ready = 1'b1;
        step();
        check("t3_resume_pc", instr_pc, 32'h2084);

        // Flush at idx 5 while a line is presented.
        while (mq.size() > 0 && mq[0].k != 5) step();
        flush = 1'b1;
        present(32'h5000, 1'b0);
        #1;
        check("t4_flush_valid", {31'b0, instr_valid}, 32'h0);
        check("t4_flush_ready", {31'b0, line_ready}, 32'h0);
        step();
        flush      = 1'b0;
        line_valid = 1'b0;
        check("t4_occ0", {30'b0, occ}, 32'h0);
        present(32'h3008, 1'b0);
        step();
        line_valid = 1'b0;
        check("t4_first_pc", instr_pc, 32'h3008);

        // Wrap of head with tail empty while a new line arrives.
        while (mq.size() > 0 && mq[0].k != 31) step();
        present(32'h4010, 1'b0);
        step();
        line_valid = 1'b0;
        check("t6_pc", instr_pc, 32'h4010);
        check("t6_occ", {30'b0, occ}, 32'h1);
        check("t6_valid", {31'b0, instr_valid}, 32'h1);

        // Asynchronous reset between edges with two lines buffered.
        instr_ready = 1'b0;
        present(32'h4100, 1'b0);
        step();
        line_valid = 1'b0;
        check("t5_occ2", {30'b0, occ}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("t5_rst_occ", {30'b0, occ}, 32'h0);
        check("t5_rst_ready", {31'b0, line_ready}, 32'h1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        present(32'h5000, 1'b0);
        step();
        line_valid = 1'b0;
        check("t5_after_occ", {30'b0, occ}, 32'h1);
        check("t5_after_pc", instr_pc, 32'h5000);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            flush       = ($urandom_range(0, 31) == 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1)
                present({$urandom, 2'b00} & 32'hFFFF_FFFC, 1'b0);
            else
                line_valid = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
